ysyx_22051013_imem_port: RTL

- Instruction-fetch responder. Accepts PC fetch requests from the pipeline fetch stage and runs one transaction on the instruction memory bus.
- Returns the 64-bit fetch word, the request PC and an error flag to the fetch stage.
- Sits between the fetch stage and the instruction memory / AXI bridge.
- Handles pipeline redirects (flush) mid-transaction by discarding stale data.

---
 rtl/ysyx_22051013_imem_pkg.sv | 29 ++
 rtl/ysyx_22051013_imem_tmo.sv | 42 ++++
 rtl/ysyx_22051013_imem_port.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_imem_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ysyx_22051013_imem_pkg;

    localparam int PC_W_DEF    = 64;
    localparam int DATA_W_DEF  = 64;
    localparam int TIMEOUT_DEF = 255;
    localparam int TMO_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_GNT  = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DROP      = 3'd3,
        ST_HOLD      = 3'd4
    } imem_state_e;

    // Fetch addresses must be 4-byte aligned; bits [1:0] must be zero.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

    // States in which the bus-wait timeout counter runs.
    function automatic logic is_tmo_state(input imem_state_e s);
        return (s == ST_WAIT_GNT) || (s == ST_WAIT_DATA) || (s == ST_DROP);
    endfunction

endpackage

// File: rtl/ysyx_22051013_imem_tmo.sv
// Saturating bus-wait timeout counter with clear/enable and expiry flag.
// Latency: expired_o is combinational on the count, asserted in the LIMIT-th enabled cycle.
// Backpressure: none; the counter sticks at all-ones and never wraps.
module ysyx_22051013_imem_tmo #(
    parameter int          W     = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Value held during the last permitted cycle; the increment out of it reaches LIMIT.
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled and not saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/ysyx_22051013_imem_port.sv
// Instruction-fetch responder: one memory transaction per accepted PC, flush-safe.
// Latency: 3 cycles accept->resp_valid with gnt on first mem_req cycle and rvalid next; misaligned 1 cycle.
// Backpressure: response held in HOLD until resp_ready; req_ready only in IDLE or HOLD&resp_ready, never under flush.
module ysyx_22051013_imem_port
    import ysyx_22051013_imem_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [PC_W-1:0]   req_pc_i,
    input  logic              flush_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [PC_W-1:0]   resp_pc_o,
    output logic [DATA_W-1:0] resp_inst_o,
    output logic              resp_err_o,
    output logic              mem_req_o,
    output logic [PC_W-1:0]   mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    imem_state_e       state_q, state_d;
    logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
    logic [DATA_W-1:0] resp_inst_q, resp_inst_d;
    logic              resp_err_q, resp_err_d;
    logic [PC_W-1:0]   mem_addr_q, mem_addr_d;

    logic req_rdy;
    logic accept;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_exp;

    assign req_rdy = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && resp_ready_i)) && !flush_i;
    assign accept  = req_valid_i && req_rdy;

    // Counter runs in the bus-wait states and restarts whenever one of them is freshly entered.
    assign tmo_en  = is_tmo_state(state_q);
    assign tmo_clr = (state_d != state_q) && is_tmo_state(state_d);

    ysyx_22051013_imem_tmo #(
        .W     (TMO_W),
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_exp)
    );

    // Next-state and payload: flush first, then bus events, then timeout; accept overrides last.
    always_comb begin
        state_d     = state_q;
        resp_pc_d   = resp_pc_q;
        resp_inst_d = resp_inst_q;
        resp_err_d  = resp_err_q;
        mem_addr_d  = mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_GNT: begin
                if (flush_i) begin
                    // A grant in the flush cycle means the beat is owed; drain it.
                    state_d = mem_gnt_i ? ST_DROP : ST_IDLE;
                end else if (mem_gnt_i) begin
                    state_d = ST_WAIT_DATA;
                end else if (tmo_exp) begin
                    state_d     = ST_HOLD;
                    resp_err_d  = 1'b1;
                    resp_inst_d = '0;
                end
            end
            ST_WAIT_DATA: begin
                if (flush_i) begin
                    // Data arriving with the flush is simply discarded.
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DROP;
                end else if (mem_rvalid_i) begin
                    state_d     = ST_HOLD;
                    resp_inst_d = mem_rdata_i;
                    resp_err_d  = mem_err_i;
                end else if (tmo_exp) begin
                    state_d     = ST_HOLD;
                    resp_err_d  = 1'b1;
                    resp_inst_d = '0;
                end
            end
            ST_DROP: begin
                if (mem_rvalid_i || tmo_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush_i || resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // req_rdy already excludes flush, so an accept never fights a flush decision.
        if (accept) begin
            resp_pc_d  = req_pc_i;
            mem_addr_d = {req_pc_i[PC_W-1:3], 3'b000};
            if (pc_misaligned(req_pc_i[1:0])) begin
                state_d     = ST_HOLD;
                resp_err_d  = 1'b1;
                resp_inst_d = '0;
            end else begin
                state_d     = ST_WAIT_GNT;
                resp_err_d  = 1'b0;
                resp_inst_d = '0;
            end
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            resp_pc_q   <= '0;
            resp_inst_q <= '0;
            resp_err_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            resp_pc_q   <= resp_pc_d;
            resp_inst_q <= resp_inst_d;
            resp_err_q  <= resp_err_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign req_ready_o  = req_rdy;
    assign resp_valid_o = (state_q == ST_HOLD);
    assign mem_req_o    = (state_q == ST_WAIT_GNT);
    assign resp_pc_o    = resp_pc_q;
    assign resp_inst_o  = resp_inst_q;
    assign resp_err_o   = resp_err_q;
    assign mem_addr_o   = mem_addr_q;

endmodule
